// File: rtl/adc_reader.sv
// adc_reader: runs one conversion and readout of an 18-bit two's-complement
// SAR ADC for each request. It drives CNV, clocks the result out over
// 3-wire SPI (SCK/SDO, CPOL=0, MSB first) and presents the signed sample.
//
// Optional build macro: ADC_READER_BUSY_WAIT_EN
//   When defined, the design adds a busy input. CONVERT then ends early,
//   as soon as the ADC BUSY pin is low. CONV_WAIT still bounds the
//   conversion as a timeout.
//
// Ports:
//   clk       system clock
//   rst       synchronous, active-high reset
//   arm       request; held high for the whole transaction
//   busy      ADC BUSY pin (only with ADC_READER_BUSY_WAIT_EN)
//   finished  sample valid; held while arm stays high
//   data      last completed sample (raw two's-complement code)
//   conv      ADC CNV pin
//   sck       SPI clock, idles low
//   sdo       ADC serial data; the ADC updates it after SCK falls
module adc_reader #(
   parameter int ADC_WID       = 18,
   parameter int CONV_WAIT     = 150,
   parameter int CONV_WAIT_WID = 8,
   parameter int SCK_HALF_PER  = 2,
   parameter int SCK_HALF_WID  = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      arm,
`ifdef ADC_READER_BUSY_WAIT_EN
   input  logic                      busy,
`endif
   output logic                      finished,
   output logic signed [ADC_WID-1:0] data,
   output logic                      conv,
   output logic                      sck,
   input  logic                      sdo
);

   localparam int BIT_WID = $clog2(ADC_WID + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CONVERT,
      S_READ,
      S_DONE
   } state_t;

   state_t                    state, state_n;
   logic                      finished_n, conv_n, sck_n;
   logic signed [ADC_WID-1:0] data_n;
   logic [ADC_WID-1:0]        shift, shift_n;
   logic [CONV_WAIT_WID-1:0]  conv_cnt, conv_cnt_n;
   logic [SCK_HALF_WID-1:0]   div, div_n;
   logic [BIT_WID-1:0]        bit_cnt, bit_cnt_n;
   logic                      conv_exit;

   // conv_cnt holds the previous edge's count, so the count "at this edge"
   // is conv_cnt+1. The exit conditions below are shifted by one to match.
`ifdef ADC_READER_BUSY_WAIT_EN
   // A count of at least 2 masks the delay before the ADC raises BUSY.
   assign conv_exit = (conv_cnt == CONV_WAIT_WID'(CONV_WAIT - 1)) ||
                      (!busy && (conv_cnt >= CONV_WAIT_WID'(1)));
`else
   assign conv_exit = (conv_cnt == CONV_WAIT_WID'(CONV_WAIT - 1));
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         finished <= 1'b0;
         data     <= '0;
         conv     <= 1'b0;
         sck      <= 1'b0;
         shift    <= '0;
         conv_cnt <= '0;
         div      <= '0;
         bit_cnt  <= '0;
      end else begin
         state    <= state_n;
         finished <= finished_n;
         data     <= data_n;
         conv     <= conv_n;
         sck      <= sck_n;
         shift    <= shift_n;
         conv_cnt <= conv_cnt_n;
         div      <= div_n;
         bit_cnt  <= bit_cnt_n;
      end
   end

   always_comb begin
      state_n    = state;
      finished_n = finished;
      data_n     = data;
      conv_n     = conv;
      sck_n      = sck;
      shift_n    = shift;
      conv_cnt_n = conv_cnt;
      div_n      = div;
      bit_cnt_n  = bit_cnt;

      case (state)
         S_IDLE: begin
            conv_n     = 1'b0;
            sck_n      = 1'b0;
            finished_n = 1'b0;
            if (arm) begin
               conv_n     = 1'b1;
               conv_cnt_n = '0;
               state_n    = S_CONVERT;
            end
         end

         S_CONVERT: begin
            if (!arm) begin
               conv_n     = 1'b0;
               sck_n      = 1'b0;
               finished_n = 1'b0;
               state_n    = S_IDLE;
            end else begin
               conv_cnt_n = conv_cnt + 1'b1;
               if (conv_exit) begin
                  conv_n    = 1'b0;
                  bit_cnt_n = BIT_WID'(ADC_WID);
                  div_n     = '0;
                  state_n   = S_READ;
               end
            end
         end

         S_READ: begin
            if (!arm) begin
               // Abort: the partial shift is dropped and data keeps the old sample.
               conv_n     = 1'b0;
               sck_n      = 1'b0;
               finished_n = 1'b0;
               state_n    = S_IDLE;
            end else if (div == SCK_HALF_WID'(SCK_HALF_PER - 1)) begin
               div_n = '0;
               sck_n = ~sck;
               if (sck) begin
                  // Falling SCK: the ADC still presents the current bit.
                  shift_n   = {shift[ADC_WID-2:0], sdo};
                  bit_cnt_n = bit_cnt - 1'b1;
                  if (bit_cnt == BIT_WID'(1)) begin
                     data_n     = {shift[ADC_WID-2:0], sdo};
                     finished_n = 1'b1;
                     state_n    = S_DONE;
                  end
               end
            end else begin
               div_n = div + 1'b1;
            end
         end

         S_DONE: begin
            conv_n     = 1'b0;
            sck_n      = 1'b0;
            finished_n = 1'b1;
            if (!arm) begin
               finished_n = 1'b0;
               state_n    = S_IDLE;
            end
         end

         default: begin
            state_n    = S_IDLE;
            conv_n     = 1'b0;
            sck_n      = 1'b0;
            finished_n = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_adc_reader.sv
module tb_adc_reader;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic arm0 = 1'b0;
   logic arm1 = 1'b0;
`ifdef ADC_READER_BUSY_WAIT_EN
   logic busy = 1'b1;
`endif

   logic               fin0, conv0, sck0, sdo0;
   logic signed [17:0] data0;
   logic               fin1, conv1, sck1, sdo1;
   logic signed [17:0] data1;

   logic [17:0] mval0 = '0, msh0;
   logic [17:0] mval1 = '0, msh1;
   int          rises0 = 0;
   int          passed = 0;
   int          total  = 0;
   int          snap;
   logic        hold_ok;

   always #5 clk = ~clk;

   adc_reader #(.ADC_WID(18), .CONV_WAIT(150), .CONV_WAIT_WID(8),
                .SCK_HALF_PER(2), .SCK_HALF_WID(4)) u0 (
      .clk(clk), .rst(rst), .arm(arm0),
`ifdef ADC_READER_BUSY_WAIT_EN
      .busy(busy),
`endif
      .finished(fin0), .data(data0), .conv(conv0), .sck(sck0), .sdo(sdo0));

   adc_reader #(.ADC_WID(18), .CONV_WAIT(1), .CONV_WAIT_WID(8),
                .SCK_HALF_PER(1), .SCK_HALF_WID(4)) u1 (
      .clk(clk), .rst(rst), .arm(arm1),
`ifdef ADC_READER_BUSY_WAIT_EN
      .busy(busy),
`endif
      .finished(fin1), .data(data1), .conv(conv1), .sck(sck1), .sdo(sdo1));

   // ADC models: the value is latched when CNV rises, MSB first, and the
   // next bit appears after each falling SCK.
   assign sdo0 = msh0[17];
   assign sdo1 = msh1[17];
   always @(posedge conv0 or negedge sck0)
      if (conv0) msh0 <= mval0; else msh0 <= {msh0[16:0], 1'b0};
   always @(posedge conv1 or negedge sck1)
      if (conv1) msh1 <= mval1; else msh1 <= {msh1[16:0], 1'b0};
   always @(posedge sck0) rises0 <= rises0 + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   initial begin
      repeat (2) tick();
      rst = 1'b0;
      tick();
      chk("rst_fin", fin0, 1'b0);
      chk("rst_data", {14'd0, data0}, 32'd0);
      chk("rst_conv", conv0, 1'b0);
      chk("rst_sck", sck0, 1'b0);

      // 1. basic sample
      mval0 = 18'h2AAAA;
      snap = rises0;
      arm0 = 1'b1;
      tick();                       // edge 0
      chk("t1_conv_e0", conv0, 1'b1);
      repeat (149) tick();          // edge 149
      chk("t1_conv_e149", conv0, 1'b1);
      tick();                       // edge 150
      chk("t1_conv_e150", conv0, 1'b0);
      chk("t1_sck_e150", sck0, 1'b0);
      repeat (2) tick();            // edge 152
      chk("t1_sck_e152", sck0, 1'b1);
      tick();
      chk("t1_sck_e153", sck0, 1'b1);
      tick();
      chk("t1_sck_e154", sck0, 1'b0);
      repeat (67) tick();           // edge 221
      chk("t1_fin_e221", fin0, 1'b0);
      tick();                       // edge 222
      chk("t1_fin_e222", fin0, 1'b1);
      chk("t1_data", {14'd0, data0}, 32'h2AAAA);
      chk("t1_pulses", rises0 - snap, 32'd18);

      // 2. hold and re-arm
      hold_ok = 1'b1;
      snap = rises0;
      repeat (10) begin
         tick();
         if (conv0 || sck0 || !fin0) hold_ok = 1'b0;
      end
      chk("t2_hold", hold_ok, 1'b1);
      chk("t2_hold_pulses", rises0 - snap, 32'd0);
      arm0 = 1'b0;
      tick();
      chk("t2_fin_drop", fin0, 1'b0);
      mval0 = 18'h1FFFF;
      arm0 = 1'b1;
      tick();                       // edge 0
      repeat (221) tick();
      chk("t2_fin_e221", fin0, 1'b0);
      tick();
      chk("t2_fin_e222", fin0, 1'b1);
      chk("t2_data", {14'd0, data0}, 32'h1FFFF);

      // 3. abort in READ
      arm0 = 1'b0;
      tick();
      mval0 = 18'h00001;
      arm0 = 1'b1;
      tick();
      repeat (222) tick();
      chk("t3_data_pre", {14'd0, data0}, 32'h00001);
      arm0 = 1'b0;
      tick();
      mval0 = 18'h3C3C3;
      arm0 = 1'b1;
      tick();                       // edge 0
      repeat (159) tick();          // edge 159, mid-READ
      chk("t3_in_read_fin", fin0, 1'b0);
      arm0 = 1'b0;
      tick();                       // edge 160
      chk("t3_sck", sck0, 1'b0);
      chk("t3_conv", conv0, 1'b0);
      chk("t3_fin", fin0, 1'b0);
      chk("t3_data", {14'd0, data0}, 32'h00001);
      repeat (100) tick();
      chk("t3_data_later", {14'd0, data0}, 32'h00001);
      chk("t3_fin_later", fin0, 1'b0);

      // 4. reset in CONVERT
      arm0 = 1'b1;
      tick();                       // edge 0
      repeat (49) tick();
      chk("t4_conv_pre", conv0, 1'b1);
      rst = 1'b1;
      arm0 = 1'b0;
      tick();                       // edge 50
      chk("t4_conv", conv0, 1'b0);
      chk("t4_sck", sck0, 1'b0);
      chk("t4_fin", fin0, 1'b0);
      chk("t4_data", {14'd0, data0}, 32'd0);
      rst = 1'b0;
      snap = rises0;
      repeat (200) tick();
      chk("t4_no_pulses", rises0 - snap, 32'd0);
      chk("t4_conv_idle", conv0, 1'b0);

      // 5. boundary parameters
      mval1 = 18'h3FFFF;
      arm1 = 1'b1;
      tick();                       // edge 0
      chk("t5_conv_e0", conv1, 1'b1);
      tick();
      chk("t5_conv_e1", conv1, 1'b0);
      repeat (35) tick();           // edge 36
      chk("t5_fin_e36", fin1, 1'b0);
      tick();                       // edge 37
      chk("t5_fin_e37", fin1, 1'b1);
      chk("t5_data", {14'd0, data1}, 32'h3FFFF);
      arm1 = 1'b0;
      tick();
      chk("t5_fin_drop", fin1, 1'b0);

`ifdef ADC_READER_BUSY_WAIT_EN
      // 6A. BUSY falls at cycle 40
      mval0 = 18'h0F0F0;
      busy = 1'b1;
      arm0 = 1'b1;
      tick();                       // edge 0
      repeat (39) tick();           // edge 39
      chk("t6a_conv_e39", conv0, 1'b1);
      busy = 1'b0;
      tick();                       // edge 40
      chk("t6a_conv_e40", conv0, 1'b0);
      busy = 1'b1;
      repeat (71) tick();
      chk("t6a_fin_e111", fin0, 1'b0);
      tick();
      chk("t6a_fin_e112", fin0, 1'b1);
      chk("t6a_data", {14'd0, data0}, 32'h0F0F0);
      arm0 = 1'b0;
      tick();
      // 6B. BUSY stuck high
      mval0 = 18'h12345;
      arm0 = 1'b1;
      tick();
      repeat (149) tick();
      chk("t6b_conv_e149", conv0, 1'b1);
      tick();
      chk("t6b_conv_e150", conv0, 1'b0);
      repeat (71) tick();
      chk("t6b_fin_e221", fin0, 1'b0);
      tick();
      chk("t6b_fin_e222", fin0, 1'b1);
      chk("t6b_data", {14'd0, data0}, 32'h12345);
      arm0 = 1'b0;
      tick();
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/adc_reader.md
Name: adc_reader

Overview:
- Upstream stage of control_loop.
- Runs one conversion-and-readout of an 18-bit two's-complement SAR ADC on request. Drives CNV, clocks out the result over 3-wire SPI (SCK/SDO) and presents a signed sample.
- Consumer side is control_loop's adc_arm / adc_finished / measured_value handshake.

Parameters:
- ADC_WID, 18, sample width in bits.
- CONV_WAIT, 150, CNV-high cycles before readout (1.5 us at 100 MHz). Must be ≥1.
- CONV_WAIT_WID, 8, width of the conversion counter.
- SCK_HALF_PER, 2, clk cycles per SCK half-period. Must be ≥1.
- SCK_HALF_WID, 4, width of the SCK divider counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- arm  input  1  request; held high for the whole transaction.
- finished  output  1  sample valid; held while arm is high.
- data  output  ADC_WID (signed)  last completed sample.
- conv  output  1  ADC CNV pin.
- sck  output  1  SPI clock, CPOL=0.
- sdo  input  1  ADC serial data, MSB first; ADC updates it after SCK falls.

Behaviour:
- Reset: state IDLE; finished=0, data=0, conv=0, sck=0; all counters 0.
- IDLE:
  - conv=0, sck=0, finished=0.
  - arm sampled high (call this edge 0) → conv=1, conversion counter cleared, go to CONVERT.
- CONVERT:
  - Counter increments every cycle.
  - At edge CONV_WAIT: conv←0, bit counter←ADC_WID, divider←0, go to READ.
- READ:
  - Divider counts SCK_HALF_PER cycles per phase; sck toggles at the end of each phase. First rising edge is SCK_HALF_PER cycles after entry.
  - sdo is shifted into the LSB of the shift register on the clk edge that drives sck 1→0. At that edge the ADC has not yet updated sdo.
  - Exactly ADC_WID SCK pulses per transaction.
  - On the edge driving the final falling SCK: data←shift register (including the final bit), finished←1, go to DONE.
- Latency: finished and data update at edge CONV_WAIT + 2·SCK_HALF_PER·ADC_WID. Defaults give 222.
- DONE:
  - finished=1, data held, conv=0, sck=0.
  - arm sampled low → finished←0, go to IDLE.
  - arm must be seen low for ≥1 cycle before a new transaction starts. Level-held arm never retriggers.
- Abort: arm low in CONVERT or READ → next edge IDLE, conv=0, sck=0, finished=0. data keeps the previous sample; the partial shift is discarded.
- Reset mid-operation: outputs go to reset values on that edge, regardless of state.
- data is the raw ADC two's-complement code; no sign manipulation.

Optional Feature:
Macro ADC_READER_BUSY_WAIT_EN.
- Defined:
  - Adds port busy (input, 1, ADC BUSY pin).
  - CONVERT ends on the first edge where busy is sampled low and the conversion counter is ≥2 (counter ≥2 masks BUSY assertion delay).
  - CONV_WAIT becomes a timeout: if busy is still high at count CONV_WAIT, CONVERT exits anyway.
  - Latency becomes the exit edge + 2·SCK_HALF_PER·ADC_WID.
- Undefined: no busy port; fixed CONV_WAIT as above.

Test Plan:
1. Basic sample:
   - Stimulus: rst 2 cycles; arm=1; ADC model drives 18'h2AAAA.
   - Response: conv high edges 1..150; 18 SCK pulses, 2 cycles high / 2 low; finished=1 exactly 222 cycles after arm sampled; data=18'h2AAAA (−87382).
2. Handshake hold/re-arm:
   - Stimulus: keep arm high 10 cycles after finished; then drop arm 1 cycle; re-arm with model value 18'h1FFFF.
   - Response: during the hold, finished stays 1 with no conv/sck activity; finished=0 one cycle after arm drops; second transaction yields data=18'h1FFFF (131071).
3. Abort in READ:
   - Stimulus: after a completed 18'h00001, re-arm; drop arm at cycle 160.
   - Response: next edge sck=0, conv=0, finished=0; data stays 18'h00001.
4. Reset in CONVERT:
   - Stimulus: rst pulse at cycle 50 of a conversion.
   - Response: next edge conv=0, sck=0, finished=0, data=0; no SCK pulses until a fresh arm.
5. Boundary parameters:
   - Stimulus: CONV_WAIT=1, SCK_HALF_PER=1; model drives 18'h3FFFF.
   - Response: finished at edge 1+36=37; data=18'h3FFFF (−1).
6. With ADC_READER_BUSY_WAIT_EN:
   - Stimulus A: busy falls at cycle 40.
   - Response A: READ starts at edge 40; finished at edge 112.
   - Stimulus B: busy stuck high.
   - Response B: timeout exit at edge 150; finished at 222.
